snoopy_bus_ctrl: RTL

Central snoop controller for the dual-core coherence fabric. It takes read/write miss requests from both L1 cache controllers over the c2snoopy request channel. It arbitrates between them with a one-bit rotating token and broadcasts the winning address as a snoop to the peer cache. It then waits for the peer's ack, optionally carrying data, and returns a one-cycle completion to the requester.

---
 rtl/snoopy_bus_ctrl_pkg.sv | 23 ++
 rtl/snoopy_bus_ctrl_if.sv | 36 +++
 rtl/snoopy_bus_ctrl_token_arb.sv | 17 +
 rtl/snoopy_bus_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/snoopy_bus_ctrl_pkg.sv
// Shared types and constants for the dual-core snoop controller.
// The transaction struct carries a fixed ADDR_W_DEF-wide address; instances keep ADDR_W <= ADDR_W_DEF.
package snoopy_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_CORES  = 2;

    typedef logic core_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        RESP  = 2'd2
    } snp_state_e;

    typedef struct packed {
        core_id_t              owner;
        logic                  wnr;
        logic [ADDR_W_DEF-1:0] addr;
    } snp_txn_t;

endpackage

// File: rtl/snoopy_bus_ctrl_if.sv
// Request/snoop/response bundle between the two L1 controllers and the snoop controller.
// master = cache side, slave = snoop controller side.
interface snoopy_bus_ctrl_if
    import snoopy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NUM_CORES-1:0]             req_valid;
    logic [NUM_CORES-1:0]             req_wnr;
    logic [NUM_CORES-1:0][ADDR_W-1:0] req_addr;

    logic [NUM_CORES-1:0]             snp_valid;
    logic                             snp_wnr;
    logic [ADDR_W-1:0]                snp_addr;
    logic [NUM_CORES-1:0]             snp_ack;
    logic [NUM_CORES-1:0]             snp_hit;
    logic [NUM_CORES-1:0][DATA_W-1:0] snp_data;

    logic [NUM_CORES-1:0]             done;
    logic                             rsp_hit;
    logic [DATA_W-1:0]                rsp_data;
    logic                             rsp_timeout;
    logic                             busy;

    modport master (
        output req_valid, req_wnr, req_addr, snp_ack, snp_hit, snp_data,
        input  snp_valid, snp_wnr, snp_addr, done, rsp_hit, rsp_data, rsp_timeout, busy
    );

    modport slave (
        input  req_valid, req_wnr, req_addr, snp_ack, snp_hit, snp_data,
        output snp_valid, snp_wnr, snp_addr, done, rsp_hit, rsp_data, rsp_timeout, busy
    );

endinterface

// File: rtl/snoopy_bus_ctrl_token_arb.sv
// Two-way request arbiter: a lone requester always wins, a tie goes to the token holder.
module snoopy_token_arb
    import snoopy_pkg::*;
(
    input  logic [NUM_CORES-1:0] i_req_valid,
    input  core_id_t             i_token,
    input  logic                 i_en,
    output logic                 o_gnt_valid,
    output core_id_t             o_gnt_id
);

    always_comb begin
        o_gnt_valid = i_en & (|i_req_valid);
        o_gnt_id    = (&i_req_valid) ? i_token : i_req_valid[1];
    end

endmodule

// File: rtl/snoopy_bus_ctrl.sv
// Snoop controller: arbitrates core misses, snoops the peer, returns a one-cycle completion.
// All bus outputs come straight from registers.
module snoopy_bus_ctrl
    import snoopy_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    snoopy_bus_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    snp_state_e           r_state, w_state_nxt;
    snp_txn_t             r_txn, w_txn_nxt;
    core_id_t             r_token, w_token_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic [NUM_CORES-1:0] r_snp_valid, w_snp_valid_nxt;
    logic [NUM_CORES-1:0] r_done, w_done_nxt;
    logic                 r_rsp_hit, w_rsp_hit_nxt;
    logic [DATA_W-1:0]    r_rsp_data, w_rsp_data_nxt;
    logic                 r_rsp_timeout, w_rsp_timeout_nxt;
    logic                 r_busy;

    logic                 w_gnt_valid;
    core_id_t             w_gnt_id;
    core_id_t             w_peer;
    logic                 w_peer_ack;
    logic                 w_expired;

    snoopy_token_arb u_arb (
        .i_req_valid (bus.req_valid),
        .i_token     (r_token),
        .i_en        (r_state == IDLE),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // Only the peer's ack counts, and only while its snoop is actually outstanding.
    assign w_peer     = ~r_txn.owner;
    assign w_peer_ack = bus.snp_ack[w_peer] & r_snp_valid[w_peer];
    assign w_expired  = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_txn         <= '0;
            r_token       <= 1'b0;
            r_timer       <= '0;
            r_snp_valid   <= '0;
            r_done        <= '0;
            r_rsp_hit     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_txn         <= w_txn_nxt;
            r_token       <= w_token_nxt;
            r_timer       <= w_timer_nxt;
            r_snp_valid   <= w_snp_valid_nxt;
            r_done        <= w_done_nxt;
            r_rsp_hit     <= w_rsp_hit_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_state_nxt = SNOOP;
            SNOOP:   if (w_peer_ack || w_expired) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_txn_nxt         = r_txn;
        w_token_nxt       = r_token;
        w_timer_nxt       = r_timer;
        w_snp_valid_nxt   = r_snp_valid;
        w_done_nxt        = '0;
        w_rsp_hit_nxt     = r_rsp_hit;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_timeout_nxt = r_rsp_timeout;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_txn_nxt.owner             = w_gnt_id;
                    w_txn_nxt.wnr               = bus.req_wnr[w_gnt_id];
                    w_txn_nxt.addr              = ADDR_W_DEF'(bus.req_addr[w_gnt_id]);
                    w_timer_nxt                 = '0;
                    w_snp_valid_nxt             = '0;
                    w_snp_valid_nxt[~w_gnt_id]  = 1'b1;
                end
            end
            SNOOP: begin
                if (w_peer_ack) begin
                    w_snp_valid_nxt           = '0;
                    w_rsp_hit_nxt             = bus.snp_hit[w_peer];
                    // Writes invalidate the peer copy; only reads carry data home.
                    w_rsp_data_nxt            = (bus.snp_hit[w_peer] && !r_txn.wnr) ?
                                                bus.snp_data[w_peer] : '0;
                    w_rsp_timeout_nxt         = 1'b0;
                    w_done_nxt[r_txn.owner]   = 1'b1;
                end else if (w_expired) begin
                    w_snp_valid_nxt           = '0;
                    w_rsp_hit_nxt             = 1'b0;
                    w_rsp_data_nxt            = '0;
                    w_rsp_timeout_nxt         = 1'b1;
                    w_done_nxt[r_txn.owner]   = 1'b1;
                end else if (r_timer != {TW{1'b1}}) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            RESP: begin
                w_rsp_hit_nxt     = 1'b0;
                w_rsp_data_nxt    = '0;
                w_rsp_timeout_nxt = 1'b0;
                w_token_nxt       = ~r_txn.owner;
            end
            default: ;
        endcase
    end

    assign bus.snp_valid   = r_snp_valid;
    assign bus.snp_wnr     = r_txn.wnr;
    assign bus.snp_addr    = ADDR_W'(r_txn.addr);
    assign bus.done        = r_done;
    assign bus.rsp_hit     = r_rsp_hit;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.busy        = r_busy;

endmodule
